// File: rtl/msix_message_generator.sv
// Purpose : MSI-X Pending Bit Array plus table-read / memory-write message sequencer.
// Latency : int_req -> pending after 1 cycle, tbl_rd_req after 2 cycles; message issued after tbl_rd_valid.
// Backpr. : the write is held stable with mwr_valid=1 until mwr_ready; requests keep accumulating in pending.
// Option  : define MSIX_FUNCTION_MASK_EN to let function_mask block eligibility (otherwise ignored).
module msix_message_generator #(
  parameter int NUM_VECTORS = 8,
  parameter int VEC_W       = $clog2(NUM_VECTORS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   msix_enable,
  input  logic                   function_mask,
  input  logic [NUM_VECTORS-1:0] int_req,
  input  logic [NUM_VECTORS-1:0] vec_mask,
  output logic                   tbl_rd_req,
  output logic [VEC_W-1:0]       tbl_rd_idx,
  input  logic                   tbl_rd_valid,
  input  logic [31:0]            tbl_addr_lo,
  input  logic [31:0]            tbl_addr_hi,
  input  logic [31:0]            tbl_data,
  output logic                   mwr_valid,
  input  logic                   mwr_ready,
  output logic [63:0]            mwr_addr,
  output logic [31:0]            mwr_data,
  output logic                   mwr_is_64,
  output logic [NUM_VECTORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, TBL_RD, SEND} state_t;

  state_t                 state;
  logic                   fmask_gate;
  logic                   enabled;
  logic [NUM_VECTORS-1:0] eligible;
  logic                   any_eligible;
  logic [VEC_W-1:0]       lowest_idx;
  logic                   accept;
  logic [NUM_VECTORS-1:0] clr_vec;
  logic                   abort_rd;
  logic                   unused_bits;

`ifdef MSIX_FUNCTION_MASK_EN
  assign fmask_gate  = function_mask;
  assign unused_bits = ^tbl_addr_lo[1:0];
`else
  assign fmask_gate  = 1'b0;
  assign unused_bits = ^{function_mask, tbl_addr_lo[1:0]};
`endif

  assign enabled      = msix_enable & ~fmask_gate;
  assign eligible     = enabled ? (pending & ~vec_mask) : '0;
  assign any_eligible = |eligible;

  // Message write completes on the handshake; only then is the selected pending bit retired.
  assign accept  = mwr_valid & mwr_ready;
  assign clr_vec = accept ? ({{(NUM_VECTORS-1){1'b0}}, 1'b1} << tbl_rd_idx) : '0;

  // A table read in flight is abandoned if its vector or the whole function stops being eligible.
  assign abort_rd = vec_mask[tbl_rd_idx] | ~enabled;

  // Fixed priority: lowest eligible index wins (scan from the top so the lowest one overwrites).
  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (eligible[i]) lowest_idx = i[VEC_W-1:0];
    end
  end

  // Pending Bit Array: new requests are OR-ed in after the clear so a coincident request survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | (msix_enable ? int_req : '0);
    end
  end

  // Control FSM: pick a vector, fetch its table entry, then hold the write until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tbl_rd_req <= 1'b0;
      tbl_rd_idx <= '0;
      mwr_valid  <= 1'b0;
      mwr_addr   <= '0;
      mwr_data   <= '0;
      mwr_is_64  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            tbl_rd_idx <= lowest_idx;
            tbl_rd_req <= 1'b1;
            state      <= TBL_RD;
          end
        end
        TBL_RD: begin
          if (abort_rd) begin
            // Read data arriving in the same cycle is dropped; pending stays set for a later retry.
            tbl_rd_req <= 1'b0;
            state      <= IDLE;
          end else if (tbl_rd_valid) begin
            tbl_rd_req <= 1'b0;
            mwr_valid  <= 1'b1;
            mwr_addr   <= {tbl_addr_hi, tbl_addr_lo[31:2], 2'b00};
            mwr_data   <= tbl_data;
            mwr_is_64  <= |tbl_addr_hi;
            state      <= SEND;
          end
        end
        SEND: begin
          // No abort path here: once committed the message always completes.
          if (mwr_ready) begin
            mwr_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          tbl_rd_req <= 1'b0;
          mwr_valid  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
